// File: rtl/adv_pkg.sv
// Shared definitions for the adventure-game input-conditioning stage.
// Holds the move-direction and control-FSM state enums, the default
// debounce/synchronizer depths, and a helper that turns a direction into
// the {n, s, e, w} one-hot move vector used by the output register.
package adv_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } cond_state_t;

  // Bit order of the result is {n, s, e, w}, matching the button vectors
  // used throughout the top level.
  function automatic logic [3:0] dir_onehot(input dir_t dir);
    logic [3:0] vec;
    vec = 4'b0000;
    case (dir)
      DIR_N:   vec = 4'b1000;
      DIR_S:   vec = 4'b0100;
      DIR_E:   vec = 4'b0010;
      DIR_W:   vec = 4'b0001;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizer + debouncer for one raw asynchronous pushbutton.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   raw        : bouncy asynchronous button level
//   level      : debounced level
//   rise       : one-cycle strobe, registered, on a debounced 0->1 flip
// The debounced level only flips after the synchronized level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import adv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  // Metastability chain; only the last stage is trusted downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any cycle where the levels agree restarts the count, so a glitch
  // shorter than the debounce window never moves the debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= synced;
        rise  <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adv_input_cond.sv
// Input-conditioning stage ahead of the adventure-game room FSM.
// Ports:
//   clk, reset              : clock and asynchronous active-high reset
//   btn_n/btn_s/btn_e/btn_w : raw asynchronous direction buttons
//   sw                      : player is in the sword room
//   win, d                  : game won / player dead, freezes movement
//   n/s/e/w                 : registered one-cycle move pulses, one per press
//   v                       : registered sticky sword-held flag
//   move_cnt                : saturating count of issued move pulses
module adv_input_cond
  import adv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  input  logic       sw,
  input  logic       win,
  input  logic       d,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       v,
  output logic [7:0] move_cnt
);

  logic [3:0]  raw_btn;
  logic [3:0]  level;
  logic [3:0]  rise;
  logic [3:0]  move_next;
  logic        stop;
  dir_t        sel_dir;
  dir_t        dir_q;
  cond_state_t state;
  cond_state_t next_state;

  // Vector order {n, s, e, w}: bit 3 is the highest-priority button.
  assign raw_btn = {btn_n, btn_s, btn_e, btn_w};
  assign stop    = win | d;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // Highest-priority rising button wins; simultaneous lower rises are dropped.
  always_comb begin
    sel_dir = DIR_N;
    if (rise[3])      sel_dir = DIR_N;
    else if (rise[2]) sel_dir = DIR_S;
    else if (rise[1]) sel_dir = DIR_E;
    else if (rise[0]) sel_dir = DIR_W;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // win/d take precedence over a same-cycle rise, and DONE is terminal.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (stop)       next_state = DONE;
        else if (|rise) next_state = FIRE;
      end
      FIRE: next_state = HOLD;
      HOLD: begin
        if (stop)            next_state = DONE;
        else if (level == 4'b0000) next_state = IDLE;
      end
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    move_next = 4'b0000;
    if (state == FIRE) move_next = dir_onehot(dir_q);
  end

  // Direction is captured only on the IDLE->FIRE transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= DIR_N;
    end else if (state == IDLE && !stop && |rise) begin
      dir_q <= sel_dir;
    end
  end

  // Moves, counter and sword flag are all registered so no input reaches an
  // output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {n, s, e, w} <= 4'b0000;
      move_cnt     <= 8'd0;
      v            <= 1'b0;
    end else begin
      {n, s, e, w} <= move_next;
      if (state == FIRE && move_cnt != 8'hFF) move_cnt <= move_cnt + 8'd1;
      if (sw) v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adv_input_cond.sv
// Self-checking bench for adv_input_cond with default parameters.
// A table of single-press vectors is applied in a loop; the multi-cycle
// corner cases (exact latency, bounce rejection, sword latch, win/dead
// freeze, saturation, reset mid-debounce) are hand-written sequences.
module tb_adv_input_cond;
  import adv_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic       sw = 1'b0, win = 1'b0, d = 1'b0;
  logic       n, s, e, w, v;
  logic [7:0] move_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int tot_n = 0, tot_s = 0, tot_e = 0, tot_w = 0, excl_err = 0;
  int snap_n, snap_s, snap_e, snap_w;
  int model_cnt;

  typedef struct {
    logic [3:0] btns;
    int         exp_n;
    int         exp_s;
    int         exp_e;
    int         exp_w;
  } vec_t;

  vec_t vecs[9];

  adv_input_cond dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .btn_s   (btn_s),
    .btn_e   (btn_e),
    .btn_w   (btn_w),
    .sw      (sw),
    .win     (win),
    .d       (d),
    .n       (n),
    .s       (s),
    .e       (e),
    .w       (w),
    .v       (v),
    .move_cnt(move_cnt)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (n) tot_n <= tot_n + 1;
    if (s) tot_s <= tot_s + 1;
    if (e) tot_e <= tot_e + 1;
    if (w) tot_w <= tot_w + 1;
    if (int'(n) + int'(s) + int'(e) + int'(w) > 1) excl_err <= excl_err + 1;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic snapshot();
    snap_n = tot_n;
    snap_s = tot_s;
    snap_e = tot_e;
    snap_w = tot_w;
  endtask

  task automatic apply_stimulus(input logic [3:0] btns, input int hold, input int rel);
    @(negedge clk);
    {btn_n, btn_s, btn_e, btn_w} = btns;
    wait_cycles(hold);
    {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
    wait_cycles(rel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
    sw = 1'b0;
    win = 1'b0;
    d = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    int first_edge;
    int pulses;

    vecs[0] = '{4'b0011, 0, 0, 1, 0};
    vecs[1] = '{4'b0001, 0, 0, 0, 1};
    vecs[2] = '{4'b1000, 1, 0, 0, 0};
    vecs[3] = '{4'b0100, 0, 1, 0, 0};
    vecs[4] = '{4'b0010, 0, 0, 1, 0};
    vecs[5] = '{4'b1111, 1, 0, 0, 0};
    vecs[6] = '{4'b0110, 0, 1, 0, 0};
    vecs[7] = '{4'b0101, 0, 1, 0, 0};
    vecs[8] = '{4'b1001, 1, 0, 0, 0};

    // Reset state.
    wait_cycles(3);
    check_output("reset_moves", int'({n, s, e, w}), 0);
    check_output("reset_v", int'(v), 0);
    check_output("reset_move_cnt", int'(move_cnt), 0);

    // Exact press latency: btn_n high before edge 0 gives n after edge 19.
    snapshot();
    @(negedge clk);
    reset = 1'b0;
    btn_n = 1'b1;
    first_edge = -1;
    pulses = 0;
    for (int k = 0; k < 220; k++) begin
      @(posedge clk);
      #1;
      if (n) begin
        pulses++;
        if (first_edge < 0) first_edge = k;
      end
    end
    check_output("latency_edge", first_edge, 19);
    check_output("latency_pulses", pulses, 1);
    check_output("latency_others", (tot_s - snap_s) + (tot_e - snap_e) + (tot_w - snap_w), 0);
    check_output("latency_move_cnt", int'(move_cnt), 1);
    @(negedge clk);
    btn_n = 1'b0;
    wait_cycles(40);

    // Bounce rejection: 5-high/5-low glitches never reach the debounced level.
    do_reset();
    snapshot();
    for (int i = 0; i < 10; i++) begin
      btn_e = 1'b1;
      wait_cycles(5);
      btn_e = 1'b0;
      wait_cycles(5);
    end
    wait_cycles(30);
    check_output("glitch_pulses", (tot_n - snap_n) + (tot_s - snap_s) + (tot_e - snap_e) + (tot_w - snap_w), 0);
    check_output("glitch_move_cnt", int'(move_cnt), 0);
    snapshot();
    apply_stimulus(4'b0010, 60, 60);
    check_output("glitch_then_stable_e", tot_e - snap_e, 1);
    check_output("glitch_then_stable_cnt", int'(move_cnt), 1);

    // Table of single presses with priority resolution.
    do_reset();
    model_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      snapshot();
      apply_stimulus(vecs[i].btns, 60, 60);
      model_cnt++;
      check_output($sformatf("vec%0d_n", i), tot_n - snap_n, vecs[i].exp_n);
      check_output($sformatf("vec%0d_s", i), tot_s - snap_s, vecs[i].exp_s);
      check_output($sformatf("vec%0d_e", i), tot_e - snap_e, vecs[i].exp_e);
      check_output($sformatf("vec%0d_w", i), tot_w - snap_w, vecs[i].exp_w);
      check_output($sformatf("vec%0d_move_cnt", i), int'(move_cnt), model_cnt);
    end

    // Sword latch: set one cycle after sw is sampled, sticky, cleared by reset.
    @(negedge clk);
    sw = 1'b1;
    check_output("v_before_edge", int'(v), 0);
    @(posedge clk);
    #1;
    check_output("v_after_edge", int'(v), 1);
    @(negedge clk);
    sw = 1'b0;
    wait_cycles(1000);
    check_output("v_sticky", int'(v), 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("v_async_reset", int'(v), 0);
    check_output("move_cnt_async_reset", int'(move_cnt), 0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);

    // win in IDLE freezes movement for good.
    @(negedge clk);
    win = 1'b1;
    wait_cycles(2);
    win = 1'b0;
    snapshot();
    apply_stimulus(4'b0100, 60, 60);
    check_output("win_pulses", (tot_n - snap_n) + (tot_s - snap_s) + (tot_e - snap_e) + (tot_w - snap_w), 0);
    check_output("win_state_done", int'(dut.state == DONE), 1);
    check_output("win_move_cnt", int'(move_cnt), 0);

    // d arriving in HOLD: the first move stands, nothing after it.
    do_reset();
    snapshot();
    btn_s = 1'b1;
    wait_cycles(30);
    d = 1'b1;
    wait_cycles(1);
    d = 1'b0;
    btn_s = 1'b0;
    wait_cycles(60);
    apply_stimulus(4'b0100, 60, 60);
    check_output("dead_s_pulses", tot_s - snap_s, 1);
    check_output("dead_state_done", int'(dut.state == DONE), 1);
    check_output("dead_move_cnt", int'(move_cnt), 1);

    // Saturation of move_cnt.
    do_reset();
    snapshot();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(4'b1000, 24, 26);
      if (i == 254) check_output("sat_reach_255", int'(move_cnt), 255);
    end
    check_output("sat_pulses", tot_n - snap_n, 300);
    check_output("sat_hold_255", int'(move_cnt), 255);

    // Reset ten cycles into a debounce aborts the press.
    snapshot();
    @(negedge clk);
    btn_n = 1'b1;
    wait_cycles(10);
    reset = 1'b1;
    btn_n = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(60);
    check_output("abort_pulses", (tot_n - snap_n) + (tot_s - snap_s) + (tot_e - snap_e) + (tot_w - snap_w), 0);
    check_output("abort_move_cnt", int'(move_cnt), 0);

    check_output("mutual_exclusion", excl_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
